// File: rtl/noc_flit_pkg.sv
// Flit layout shared by the NoC sink blocks: widths, field positions, field
// accessors and the sink control state encoding.
package noc_flit_pkg;

  localparam int FLIT_W      = 20;
  localparam int NODE_W      = 4;
  localparam int PAYLOAD_W   = 4;
  localparam int SRC_LSB     = 12;
  localparam int DEST_LSB    = 4;
  localparam int PAYLOAD_LSB = 0;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [NODE_W-1:0] node_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } sink_state_t;

  function automatic node_t flit_src(input flit_t f);
    return f[SRC_LSB +: NODE_W];
  endfunction

  function automatic node_t flit_dest(input flit_t f);
    return f[DEST_LSB +: NODE_W];
  endfunction

endpackage

// File: rtl/datain_flit_check.sv
// Splits a flit into its src/dest ids and flags whether it is addressed to
// this node.
module datain_flit_check
  import noc_flit_pkg::*;
#(
  parameter int NODE_ID = 3
) (
  input  logic [FLIT_W-1:0] flit,
  output logic              match,
  output logic [NODE_W-1:0] src,
  output logic [NODE_W-1:0] dest
);

  localparam logic [NODE_W-1:0] NODE_C = NODE_W'(NODE_ID);

  assign src   = flit_src(flit);
  assign dest  = flit_dest(flit);
  assign match = (dest == NODE_C);

endmodule

// File: rtl/datain_sink_buf.sv
// Receive-side flit sink: DEPTH-entry FIFO (non power-of-2 capable) with a
// run-tracking FSM. Define DATAIN_SINK_BUF_CHECK_EN to drop misrouted flits.
module datain_sink_buf
  import noc_flit_pkg::*;
#(
  parameter int NODE_ID  = 3,
  parameter int DEPTH    = 30,
  parameter int EXPECTED = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] datain,
  output logic              in_ready,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [4:0]        count,
  output logic [5:0]        rx_total,
  output logic              done,
  output logic              overflow,
  output logic              err_misroute,
  output logic [3:0]        err_count
);

  localparam logic [4:0] DEPTH_C    = 5'(DEPTH);
  localparam logic [4:0] LAST_C     = 5'(DEPTH - 1);
  localparam logic [5:0] EXPECTED_C = 6'(EXPECTED);

  logic [FLIT_W-1:0] mem [DEPTH];

  logic [4:0]        wr_ptr_reg, rd_ptr_reg, count_reg, count_next;
  logic [5:0]        rx_total_reg, rx_total_next;
  logic [FLIT_W-1:0] rd_data_reg;
  logic              rd_valid_reg, overflow_reg, err_misroute_reg;
  logic [3:0]        err_count_reg;
  sink_state_t       state_reg;

  logic              accept, store, misroute, pop, reached;
  logic              chk_match;
  logic [NODE_W-1:0] chk_src, chk_dest;

  datain_flit_check #(.NODE_ID(NODE_ID)) u_check (
    .flit  (datain),
    .match (chk_match),
    .src   (chk_src),
    .dest  (chk_dest)
  );

  assign in_ready = (count_reg != DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign pop      = rd_en && (count_reg != 5'd0);

`ifdef DATAIN_SINK_BUF_CHECK_EN
  logic [2*NODE_W-1:0] chk_unused;
  assign chk_unused = {chk_src, chk_dest};
  assign store      = accept && chk_match;
  assign misroute   = accept && !chk_match;
`else
  logic [2*NODE_W:0] chk_unused;
  assign chk_unused = {chk_match, chk_src, chk_dest};
  assign store      = accept;
  assign misroute   = 1'b0;
`endif

  // store implies count < DEPTH, so this never exceeds DEPTH or underflows
  assign count_next    = count_reg + 5'(store) - 5'(pop);
  assign rx_total_next = rx_total_reg + 6'(store && (rx_total_reg != 6'd63));
  assign reached       = store && (rx_total_next == EXPECTED_C);

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr_reg] <= datain;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      rx_total_reg     <= '0;
      rd_data_reg      <= '0;
      rd_valid_reg     <= 1'b0;
      overflow_reg     <= 1'b0;
      err_misroute_reg <= 1'b0;
      err_count_reg    <= '0;
      state_reg        <= ST_IDLE;
    end else begin
      count_reg    <= count_next;
      rx_total_reg <= rx_total_next;
      rd_valid_reg <= pop;
      if (store) wr_ptr_reg <= (wr_ptr_reg == LAST_C) ? 5'd0 : wr_ptr_reg + 5'd1;
      if (pop) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= (rd_ptr_reg == LAST_C) ? 5'd0 : rd_ptr_reg + 5'd1;
      end
      if (in_valid && !in_ready) overflow_reg <= 1'b1;
      if (misroute) begin
        err_misroute_reg <= 1'b1;
        if (err_count_reg != 4'hF) err_count_reg <= err_count_reg + 4'd1;
      end
      case (state_reg)
        ST_IDLE:   if (accept) state_reg <= reached ? ST_DONE : ST_ACTIVE;
        ST_ACTIVE: if (reached) state_reg <= ST_DONE;
        default:   state_reg <= ST_DONE;
      endcase
    end
  end

  assign count        = count_reg;
  assign rx_total     = rx_total_reg;
  assign rd_data      = rd_data_reg;
  assign rd_valid     = rd_valid_reg;
  assign done         = (state_reg == ST_DONE);
  assign overflow     = overflow_reg;
  assign err_misroute = err_misroute_reg;
  assign err_count    = err_count_reg;

endmodule

// File: tb/tb_datain_sink_buf.sv
// Directed bench for datain_sink_buf (default parameters, either value of
// DATAIN_SINK_BUF_CHECK_EN).
module tb_datain_sink_buf;

  logic        clk = 1'b0;
  logic        rst, in_valid, rd_en;
  logic [19:0] datain;
  logic        in_ready, rd_valid, done, overflow, err_misroute;
  logic [19:0] rd_data;
  logic [4:0]  count;
  logic [5:0]  rx_total;
  logic [3:0]  err_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  datain_sink_buf dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .datain       (datain),
    .in_ready     (in_ready),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .rx_total     (rx_total),
    .done         (done),
    .overflow     (overflow),
    .err_misroute (err_misroute),
    .err_count    (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flit addressed to node 3 with the given src id and payload nibble.
  function automatic logic [19:0] mk(input int s, input int p);
    logic [3:0] s4, p4;
    s4 = s[3:0];
    p4 = p[3:0];
    return {4'h0, s4, 4'h0, 4'h3, p4};
  endfunction

  function automatic logic [19:0] fill_flit(input int i);
    return mk(i % 16, (i * 7 + 1) % 16);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; rd_en = 1'b0; datain = '0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_rx_total", rx_total, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err_misroute", err_misroute, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b1;
    step();
    chk("in_ready_after_rst", in_ready, 1);

    // 15 back-to-back flits 0X033, X != 3
    n = 0;
    for (int x = 0; x < 16; x++) begin
      if (x != 3) begin
        in_valid = 1'b1;
        datain   = mk(x, 3);
        step();
        n++;
        if (n == 14) chk("done_before_15th", done, 0);
      end
    end
    in_valid = 1'b0;
    chk("run_count", count, 15);
    chk("run_rx_total", rx_total, 15);
    chk("run_done", done, 1);
    chk("run_overflow", overflow, 0);

    // misrouted flit (dest 4)
    in_valid = 1'b1; datain = 20'h01044;
    step();
    in_valid = 1'b0;
`ifdef DATAIN_SINK_BUF_CHECK_EN
    chk("mis_err_misroute", err_misroute, 1);
    chk("mis_err_count", err_count, 1);
    chk("mis_count", count, 15);
    chk("mis_rx_total", rx_total, 15);
`else
    chk("mis_err_misroute", err_misroute, 0);
    chk("mis_err_count", err_count, 0);
    chk("mis_count", count, 16);
    chk("mis_rx_total", rx_total, 16);
`endif
    chk("mis_done_sticky", done, 1);

    // fill to DEPTH, then overflow
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst2_count", count, 0);
    chk("rst2_done", done, 0);
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      datain   = fill_flit(i);
      step();
    end
    in_valid = 1'b0;
    chk("full_count", count, 30);
    chk("full_in_ready", in_ready, 0);
    chk("full_overflow_pre", overflow, 0);
    in_valid = 1'b1; datain = 20'h05033;
    step();
    in_valid = 1'b0;
    chk("ovf_overflow", overflow, 1);
    chk("ovf_count", count, 30);

    // write+pop while full: write refused, pop proceeds
    in_valid = 1'b1; datain = 20'h0A03A; rd_en = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fullrw_count", count, 29);
    chk("fullrw_rd_valid", rd_valid, 1);
    chk("fullrw_rd_data", rd_data, fill_flit(0));
    for (int i = 1; i < 30; i++) begin
      step();
      chk($sformatf("drain_valid_%0d", i), rd_valid, 1);
      chk($sformatf("drain_data_%0d", i), rd_data, fill_flit(i));
    end
    rd_en = 1'b0;
    chk("drain_count", count, 0);

    // pop at empty is ignored
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_rd_valid", rd_valid, 0);
    chk("empty_rd_data", rd_data, fill_flit(29));
    chk("empty_count", count, 0);

    // 10 entries across the wrapped pointers, then write+pop together
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      datain   = mk(2, i);
      step();
    end
    chk("ten_count", count, 10);
    datain = mk(9, 15); rd_en = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ten_rw_count", count, 10);
    chk("ten_rw_rd_valid", rd_valid, 1);
    chk("ten_rw_rd_data", rd_data, mk(2, 0));
    step(); step(); step();
    rd_en = 1'b0;
    chk("seven_count", count, 7);
    chk("seven_rd_data", rd_data, mk(2, 3));

    // reset mid-run with a pop request in the reset cycle
    rst = 1'b0; rd_en = 1'b1;
    step();
    chk("midrst_count", count, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_rx_total", rx_total, 0);
    rst = 1'b1; rd_en = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_rst_rd_valid", rd_valid, 0);
    chk("post_rst_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/datain_sink_buf.md
DATAIN_SINK_BUF -- requirements
Module: datain_sink_buf

Interface
REQ-001 The block SHALL have parameter NODE_ID, default 3, giving the local node number (0-15) that flits are checked against.
REQ-002 The block SHALL have parameter DEPTH, default 30, giving the number of storage entries (2-31).
REQ-003 The block SHALL have parameter EXPECTED, default 15, giving the number of valid flits that completes a run.
REQ-004 clk  input  1  Single clock, rising edge.
REQ-005 rst  input  1  Reset, synchronous, active-low.
REQ-006 in_valid  input  1  datain carries a flit this cycle.
REQ-007 datain  input  20  Flit: [15:12] src id, [7:4] dest id, [3:0] payload nibble, [19:16] and [11:8] reserved.
REQ-008 in_ready  output  1  Space is available; a flit is accepted when in_valid and in_ready are both 1.
REQ-009 rd_en  input  1  Pop request from the local consumer.
REQ-010 rd_data  output  20  Popped flit, registered.
REQ-011 rd_valid  output  1  rd_data is valid; one-cycle pulse.
REQ-012 count  output  5  Current number of stored entries.
REQ-013 rx_total  output  6  Number of accepted, correctly routed flits; saturates at 63.
REQ-014 done  output  1  Sticky; rx_total has reached EXPECTED.
REQ-015 overflow  output  1  Sticky; in_valid was seen while in_ready was 0.
REQ-016 err_misroute  output  1  Sticky; an accepted flit had dest id not equal to NODE_ID.
REQ-017 err_count  output  4  Number of misrouted flits; saturates at 15.

Function
REQ-018 Storage SHALL be a FIFO of DEPTH entries with write and read pointers that wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
REQ-019 in_ready SHALL be combinational and equal to (count != DEPTH).
REQ-020 An accepted, correctly routed flit SHALL be written at the write pointer; count SHALL increment on the next edge.
REQ-021 rd_en with count != 0 SHALL pop; rd_data and rd_valid=1 SHALL appear the cycle after rd_en (latency 1).
REQ-022 rd_en with count == 0 SHALL be ignored: rd_valid=0, and neither pointer nor rd_data changes.
REQ-023 A simultaneous write and pop SHALL leave count unchanged; at count==DEPTH the write is refused and only the pop proceeds.
REQ-024 in_valid with in_ready=0 SHALL drop the flit and set overflow; FIFO contents are unchanged.
REQ-025 The control FSM SHALL have states IDLE, ACTIVE and DONE: IDLE->ACTIVE on the first accepted flit; ACTIVE->DONE on the edge where rx_total becomes EXPECTED; DONE holds until reset.
REQ-026 done SHALL equal (state==DONE); in DONE, flits continue to be accepted, stored and counted.
REQ-027 rx_total SHALL count correctly routed flits only, and SHALL saturate at 63 without wrapping.

Reset
REQ-028 On a clk edge with rst=0, all of the following SHALL be cleared: pointers, count=0, rx_total=0, state=IDLE, done=0, overflow=0, err_misroute=0, err_count=0, rd_valid=0, rd_data=20'h00000.
REQ-029 Reset asserted mid-run SHALL discard all stored flits; any rd_en in the reset cycle produces no rd_valid.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-031 With DATAIN_SINK_BUF_CHECK_EN defined, a flit with datain[7:4]!=NODE_ID SHALL be accepted but not stored, SHALL set err_misroute, and SHALL increment err_count.
REQ-032 Without DATAIN_SINK_BUF_CHECK_EN, every accepted flit SHALL be stored and counted in rx_total, and err_misroute and err_count SHALL be tied to 0.

Structure
REQ-033 Package noc_flit_pkg SHALL hold the flit width (20), the field positions for src, dest and payload, and the node-id width (4).
REQ-034 The dest comparison SHALL be a sub-module datain_flit_check (flit, NODE_ID -> match, src, dest); the FIFO and FSM SHALL stay in the top level.

Verification
REQ-035 Reset, then 15 flits 20'h0X033 (X = src 0-15, excluding 3), back-to-back -> count=15, rx_total=15, done=1 one cycle after the 15th edge, overflow=0.
REQ-036 With CHECK_EN, inject 20'h01044 -> err_misroute=1, err_count=1, count unchanged; without CHECK_EN -> count+1, error outputs 0.
REQ-037 EXPECTED=40: write 30 flits with no reads, then in_valid with 20'h05033 -> in_ready=0, overflow=1, count=30; then rd_en x30 -> flits returned in order, pointer wrap at 29->0.
REQ-038 count=30 with in_valid and rd_en both 1 -> write refused, pop succeeds, count=29; at count=10 with both -> count stays 10.
REQ-039 rd_en at count=0 -> rd_valid=0, rd_data keeps its last value; rst=0 asserted at count=7 -> count=0 and done=0 on the next edge.
